// File: rtl/cpu_commit_checker.sv
`default_nettype none
// ============================================================================
// Module      : cpu_commit_checker
// Description : Lockstep golden model for the single-cycle MIPS-subset CPU.
//               Captures each commit, recomputes the result from a shadow
//               register file and expected PC, and flags mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_commit_checker #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b1,
  parameter bit R0_ZERO     = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        cm_valid_i,
  input  logic [ADDR_W-1:0]           cm_pc_i,
  input  logic [31:0]                 cm_instr_i,
  input  logic [ADDR_W-1:0]           cm_next_pc_i,
  input  logic                        cm_we_i,
  input  logic [$clog2(NUM_REGS)-1:0] cm_waddr_i,
  input  logic [DATA_W-1:0]           cm_wdata_i,
  output logic                        err_o,
  output logic [2:0]                  err_code_o,
  output logic [ADDR_W-1:0]           err_pc_o,
  output logic [CNT_W-1:0]            chk_cnt_o,
  output logic [CNT_W-1:0]            err_cnt_o,
  output logic [1:0]                  state_o
);

  localparam int RA_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  // captured commit (one cycle behind the CPU)
  logic              cap_valid;
  logic [ADDR_W-1:0] cap_pc;
  logic [31:0]       cap_instr;
  logic [ADDR_W-1:0] cap_next_pc;
  logic              cap_we;
  logic [RA_W-1:0]   cap_waddr;
  logic [DATA_W-1:0] cap_wdata;

  // golden architectural state
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [ADDR_W-1:0] exp_pc;

  // decode fields of the captured instruction
  logic [5:0]        op, funct;
  logic [RA_W-1:0]   rs_idx, rt_idx, rd_idx;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs_val, rt_val;

  // golden result
  logic              g_we;
  logic [RA_W-1:0]   g_addr;
  logic [DATA_W-1:0] g_data;
  logic [ADDR_W-1:0] g_next;
  logic              g_illegal;

  logic [2:0]        code_nxt;
  logic              is_end, active, do_check, has_err;

  assign op     = cap_instr[31:26];
  assign funct  = cap_instr[5:0];
  assign rs_idx = cap_instr[21 +: RA_W];
  assign rt_idx = cap_instr[16 +: RA_W];
  assign rd_idx = cap_instr[11 +: RA_W];
  assign shamt  = cap_instr[10:6];
  assign imm    = cap_instr[15:0];
  assign rs_val = shadow[rs_idx];
  assign rt_val = shadow[rt_idx];

  assign is_end   = (cap_instr == 32'h0);
  assign active   = cap_valid && (state == RUN);
  assign do_check = active && !is_end;
  assign has_err  = (code_nxt != 3'd0);
  assign state_o  = state;

  // capture the commit port; reset or clear discards any pending capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_valid   <= 1'b0;
      cap_pc      <= '0;
      cap_instr   <= '0;
      cap_next_pc <= '0;
      cap_we      <= 1'b0;
      cap_waddr   <= '0;
      cap_wdata   <= '0;
    end else if (clear_i) begin
      cap_valid   <= 1'b0;
      cap_pc      <= '0;
      cap_instr   <= '0;
      cap_next_pc <= '0;
      cap_we      <= 1'b0;
      cap_waddr   <= '0;
      cap_wdata   <= '0;
    end else begin
      cap_valid   <= cm_valid_i;
      cap_pc      <= cm_pc_i;
      cap_instr   <= cm_instr_i;
      cap_next_pc <= cm_next_pc_i;
      cap_we      <= cm_we_i;
      cap_waddr   <= cm_waddr_i;
      cap_wdata   <= cm_wdata_i;
    end
  end

  // execute the captured instruction against the shadow state
  always_comb begin
    g_we      = 1'b0;
    g_addr    = rt_idx;
    g_data    = '0;
    g_next    = exp_pc + ADDR_W'(4);
    g_illegal = 1'b0;
    case (op)
      6'b000000: begin
        g_we   = 1'b1;
        g_addr = rd_idx;
        case (funct)
          6'b010010: g_data = rs_val + rt_val;
          6'b010000: g_data = rs_val - rt_val;
          6'b010100: g_data = rs_val & rt_val;
          6'b010110: g_data = rs_val | rt_val;
          6'b010101: g_data = ~(rs_val | rt_val);
          6'b100000: g_data = {{(DATA_W-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
          6'b000000: g_data = rt_val << shamt;
          6'b000010: g_data = rt_val >> shamt;
          // a shift amount of DATA_W or more naturally yields zero here
          6'b000110: g_data = rt_val << rs_val;
          6'b000100: g_data = rt_val >> rs_val;
          default: begin
            g_we      = 1'b0;
            g_illegal = 1'b1;
          end
        endcase
      end
      6'b001000: begin
        g_we   = 1'b1;
        g_data = rs_val + {{(DATA_W-16){imm[15]}}, imm};
      end
      6'b001101: begin
        g_we   = 1'b1;
        g_data = rs_val | {{(DATA_W-16){1'b0}}, imm};
      end
      6'b001111: begin
        g_we   = 1'b1;
        g_data = rs_val + ({{(DATA_W-16){1'b0}}, imm} << 16);
      end
      6'b000100: begin
        if (rs_val == rt_val) begin
          g_next = exp_pc + ADDR_W'(4) + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
        end
      end
      default: g_illegal = 1'b1;
    endcase
  end

  // first failing check in priority order gives the error code
  always_comb begin
    code_nxt = 3'd0;
    if (do_check) begin
      if (cap_pc != exp_pc)                  code_nxt = 3'd1;
      else if (cap_next_pc != g_next)        code_nxt = 3'd2;
      else if (cap_we != g_we)               code_nxt = 3'd3;
      else if (g_we && cap_waddr != g_addr)  code_nxt = 3'd4;
      else if (g_we && cap_wdata != g_data)  code_nxt = 3'd5;
      else if (g_illegal)                    code_nxt = 3'd6;
    end
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        state <= RUN;
    else if (clear_i) state <= RUN;
    else              state <= state_nxt;
  end

  // next-state: end marker finishes the run, an error may halt it
  always_comb begin
    state_nxt = state;
    if (active) begin
      if (is_end)                       state_nxt = DONE;
      else if (has_err && STOP_ON_ERR)  state_nxt = HALT;
    end
  end

  // shadow registers and expected PC advance only from the golden result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      exp_pc <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      exp_pc <= '0;
    end else if (do_check) begin
      exp_pc <= g_next;
      if (g_we && !(R0_ZERO && g_addr == '0)) shadow[g_addr] <= g_data;
    end
  end

  // saturating counters and first-error latch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chk_cnt_o  <= '0;
      err_cnt_o  <= '0;
      err_o      <= 1'b0;
      err_code_o <= 3'd0;
      err_pc_o   <= '0;
    end else if (clear_i) begin
      chk_cnt_o  <= '0;
      err_cnt_o  <= '0;
      err_o      <= 1'b0;
      err_code_o <= 3'd0;
      err_pc_o   <= '0;
    end else if (do_check) begin
      if (chk_cnt_o != '1) chk_cnt_o <= chk_cnt_o + 1'b1;
      if (has_err) begin
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
        if (!err_o) begin
          err_o      <= 1'b1;
          err_code_o <= code_nxt;
          err_pc_o   <= cap_pc;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_commit_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_commit_checker
// Description : Self-checking bench: a reference CPU generates commits, a
//               behavioural checker model predicts the outputs of two DUTs
//               (halt-on-error, and continue-on-error with 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_commit_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        cm_valid = 1'b0;
  logic [31:0] cm_pc = '0, cm_instr = '0, cm_next_pc = '0, cm_wdata = '0;
  logic        cm_we = 1'b0;
  logic [4:0]  cm_waddr = '0;

  logic        h_err, c_err;
  logic [2:0]  h_code, c_code;
  logic [31:0] h_errpc, c_errpc;
  logic [15:0] h_chk, h_ecnt;
  logic [3:0]  c_chk, c_ecnt;
  logic [1:0]  h_state, c_state;

  always #5 clk = ~clk;

  cpu_commit_checker dut_h (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .cm_valid_i(cm_valid),
    .cm_pc_i(cm_pc), .cm_instr_i(cm_instr), .cm_next_pc_i(cm_next_pc),
    .cm_we_i(cm_we), .cm_waddr_i(cm_waddr), .cm_wdata_i(cm_wdata),
    .err_o(h_err), .err_code_o(h_code), .err_pc_o(h_errpc),
    .chk_cnt_o(h_chk), .err_cnt_o(h_ecnt), .state_o(h_state)
  );

  cpu_commit_checker #(.CNT_W(4), .STOP_ON_ERR(1'b0)) dut_c (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .cm_valid_i(cm_valid),
    .cm_pc_i(cm_pc), .cm_instr_i(cm_instr), .cm_next_pc_i(cm_next_pc),
    .cm_we_i(cm_we), .cm_waddr_i(cm_waddr), .cm_wdata_i(cm_wdata),
    .err_o(c_err), .err_code_o(c_code), .err_pc_o(c_errpc),
    .chk_cnt_o(c_chk), .err_cnt_o(c_ecnt), .state_o(c_state)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } cm_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] next;
    logic        illegal;
  } gold_t;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // model state per instance: 0 = halt-on-error, 1 = continue
  logic [31:0] m_regs [2][32];
  logic [31:0] m_pc [2];
  int          m_state [2];
  logic        m_err [2];
  int          m_code [2];
  logic [31:0] m_errpc [2];
  int          m_chk [2];
  int          m_ecnt [2];
  int          m_max [2] = '{65535, 15};
  bit          m_stop [2] = '{1'b1, 1'b0};

  // reference CPU producing correct commits
  logic [31:0] cpu_regs [32];
  logic [31:0] cpu_pc;

  cm_t p0, p1;
  bit  clr_q = 1'b0;
  logic [5:0] fl [10] = '{6'h12, 6'h10, 6'h14, 6'h16, 6'h15, 6'h20, 6'h00, 6'h02, 6'h06, 6'h04};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic gold_t golden(input logic [31:0] pc, input logic [31:0] ins,
                                   input logic [31:0] rsv, input logic [31:0] rtv);
    gold_t g;
    logic [15:0] im;
    im = ins[15:0];
    g = '0;
    g.next = pc + 32'd4;
    if (ins[31:26] == 6'd0) begin
      g.we = 1'b1;
      g.addr = ins[15:11];
      case (ins[5:0])
        6'h12: g.data = rsv + rtv;
        6'h10: g.data = rsv - rtv;
        6'h14: g.data = rsv & rtv;
        6'h16: g.data = rsv | rtv;
        6'h15: g.data = ~(rsv | rtv);
        6'h20: g.data = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
        6'h00: g.data = rtv << ins[10:6];
        6'h02: g.data = rtv >> ins[10:6];
        6'h06: g.data = (rsv >= 32) ? 32'd0 : (rtv << rsv[4:0]);
        6'h04: g.data = (rsv >= 32) ? 32'd0 : (rtv >> rsv[4:0]);
        default: begin g.we = 1'b0; g.illegal = 1'b1; end
      endcase
    end else begin
      g.addr = ins[20:16];
      case (ins[31:26])
        6'h08: begin g.we = 1'b1; g.data = rsv + {{16{im[15]}}, im}; end
        6'h0D: begin g.we = 1'b1; g.data = rsv | {16'h0, im}; end
        6'h0F: begin g.we = 1'b1; g.data = rsv + {im, 16'h0}; end
        6'h04: if (rsv == rtv) g.next = pc + 32'd4 + {{14{im[15]}}, im, 2'b00};
        default: g.illegal = 1'b1;
      endcase
    end
    return g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) m_regs[i][r] = '0;
      m_pc[i] = '0; m_state[i] = 0; m_err[i] = 1'b0; m_code[i] = 0;
      m_errpc[i] = '0; m_chk[i] = 0; m_ecnt[i] = 0;
    end
    for (int r = 0; r < 32; r++) cpu_regs[r] = '0;
    cpu_pc = '0;
  endtask

  task automatic model_apply(input cm_t c);
    gold_t g;
    int    code;
    for (int i = 0; i < 2; i++) begin
      if (c.valid && m_state[i] == 0) begin
        if (c.instr == 32'h0) begin
          m_state[i] = 2;
        end else begin
          g = golden(m_pc[i], c.instr, m_regs[i][c.instr[25:21]], m_regs[i][c.instr[20:16]]);
          code = 0;
          if (c.pc != m_pc[i])                     code = 1;
          else if (c.next_pc != g.next)            code = 2;
          else if (c.we != g.we)                   code = 3;
          else if (g.we && c.waddr != g.addr)      code = 4;
          else if (g.we && c.wdata != g.data)      code = 5;
          else if (g.illegal)                      code = 6;
          if (m_chk[i] < m_max[i]) m_chk[i]++;
          if (code != 0) begin
            if (m_ecnt[i] < m_max[i]) m_ecnt[i]++;
            if (!m_err[i]) begin
              m_err[i] = 1'b1; m_code[i] = code; m_errpc[i] = c.pc;
            end
            if (m_stop[i]) m_state[i] = 1;
          end
          if (g.we && g.addr != 5'd0) m_regs[i][g.addr] = g.data;
          m_pc[i] = g.next;
        end
      end
    end
  endtask

  task automatic cpu_exec(input logic [31:0] ins, output cm_t c);
    gold_t g;
    g = golden(cpu_pc, ins, cpu_regs[ins[25:21]], cpu_regs[ins[20:16]]);
    c.valid   = 1'b1;
    c.pc      = cpu_pc;
    c.instr   = ins;
    c.next_pc = g.next;
    c.we      = g.we;
    c.waddr   = g.we ? g.addr : 5'($urandom);
    c.wdata   = g.we ? g.data : $urandom;
    if (g.we && g.addr != 5'd0) cpu_regs[g.addr] = g.data;
    cpu_pc = g.next;
  endtask

  // a commit driven in one cycle is captured at the next edge and retired at the one after
  task automatic edge_step();
    @(posedge clk);
    if (clr_q) begin
      model_reset();
      p1 = '0;
    end else begin
      model_apply(p1);
      p1 = p0;
    end
    clr_q = 1'b0;
  endtask

  task automatic drive(input cm_t c, input bit clr);
    edge_step();
    #1;
    cm_valid = c.valid; cm_pc = c.pc; cm_instr = c.instr; cm_next_pc = c.next_pc;
    cm_we = c.we; cm_waddr = c.waddr; cm_wdata = c.wdata; clear = clr;
    p0 = clr ? cm_t'(0) : c;
    clr_q = clr;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive('0, 1'b0);
  endtask

  task automatic do_clear();
    drive('0, 1'b1);
    idle(1);
  endtask

  task automatic commit(input logic [31:0] ins);
    cm_t c;
    cpu_exec(ins, c);
    drive(c, 1'b0);
  endtask

  task automatic settle();
    idle(2);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    edge_step();
    #1;
    rst = 1'b1; cm_valid = 1'b0; clear = 1'b0;
    model_reset();
    p0 = '0; p1 = '0; clr_q = 1'b0;
    edge_step();
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] im);
    return {op, 5'(rs), 5'(rt), im};
  endfunction

  // every cycle both DUTs are compared against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("h_err",   32'(h_err),   32'(m_err[0]));
      chk("h_code",  32'(h_code),  m_code[0]);
      chk("h_errpc", h_errpc,      m_errpc[0]);
      chk("h_chk",   32'(h_chk),   m_chk[0]);
      chk("h_ecnt",  32'(h_ecnt),  m_ecnt[0]);
      chk("h_state", 32'(h_state), m_state[0]);
      chk("c_err",   32'(c_err),   32'(m_err[1]));
      chk("c_code",  32'(c_code),  m_code[1]);
      chk("c_errpc", c_errpc,      m_errpc[1]);
      chk("c_chk",   32'(c_chk),   m_chk[1]);
      chk("c_ecnt",  32'(c_ecnt),  m_ecnt[1]);
      chk("c_state", 32'(c_state), m_state[1]);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cm_t c;
    logic [31:0] ins;
    int k, et;
    model_reset();
    p0 = '0; p1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'(h_state), 32'd0);
    chk("reset_chk", 32'(h_chk), 32'd0);

    // addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2
    commit(i_ins(6'h08, 0, 1, 16'd5));
    commit(i_ins(6'h08, 0, 2, 16'hFFFD));
    cpu_exec(r_ins(1, 2, 3, 0, 6'h12), c);
    chk("t1_add_wdata", c.wdata, 32'd2);
    drive(c, 1'b0);
    settle();
    chk("t1_chk", 32'(h_chk), 32'd3);
    chk("t1_err", 32'(h_err), 32'd0);
    chk("t1_shadow_r3", m_regs[0][3], 32'd2);

    // same sequence, r3 written as 3
    do_clear();
    commit(i_ins(6'h08, 0, 1, 16'd5));
    commit(i_ins(6'h08, 0, 2, 16'hFFFD));
    cpu_exec(r_ins(1, 2, 3, 0, 6'h12), c);
    c.wdata = 32'd3;
    drive(c, 1'b0);
    settle();
    chk("t2_err", 32'(h_err), 32'd1);
    chk("t2_code", 32'(h_code), 32'd5);
    chk("t2_errpc", h_errpc, 32'd8);
    chk("t2_state", 32'(h_state), 32'd1);
    chk("t2_chk", 32'(h_chk), 32'd3);

    // beq r1,r1,+2 at pc 12 with wrong and then right next pc
    do_clear();
    commit(i_ins(6'h08, 0, 1, 16'd5));
    commit(i_ins(6'h08, 0, 2, 16'hFFFD));
    commit(r_ins(1, 2, 3, 0, 6'h12));
    cpu_exec(i_ins(6'h04, 1, 1, 16'd2), c);
    chk("t3_beq_target", c.next_pc, 32'd24);
    c.next_pc = 32'd16;
    drive(c, 1'b0);
    settle();
    chk("t3_code", 32'(h_code), 32'd2);
    chk("t3_errpc", h_errpc, 32'd12);
    do_clear();
    commit(i_ins(6'h08, 0, 1, 16'd5));
    commit(i_ins(6'h08, 0, 2, 16'hFFFD));
    commit(r_ins(1, 2, 3, 0, 6'h12));
    commit(i_ins(6'h04, 1, 1, 16'd2));
    commit(i_ins(6'h0D, 0, 9, 16'h00F0));
    settle();
    chk("t3_ok_err", 32'(h_err), 32'd0);
    chk("t3_ok_chk", 32'(h_chk), 32'd5);

    // continue-on-error instance: good, three bad, good
    do_clear();
    commit(i_ins(6'h08, 0, 1, 16'd1));
    for (int j = 0; j < 3; j++) begin
      cpu_exec(i_ins(6'h08, 1, 1, 16'd1), c);
      c.wdata = c.wdata ^ 32'h8000_0000;
      drive(c, 1'b0);
    end
    commit(i_ins(6'h08, 1, 1, 16'd1));
    settle();
    chk("t4_ecnt", 32'(c_ecnt), 32'd3);
    chk("t4_chk", 32'(c_chk), 32'd5);
    chk("t4_state", 32'(c_state), 32'd0);
    chk("t4_errpc", c_errpc, 32'd4);

    // lui / srlv by 40 / signed slt
    do_clear();
    cpu_exec(i_ins(6'h0F, 0, 4, 16'h8000), c);
    chk("t5_lui", c.wdata, 32'h8000_0000);
    drive(c, 1'b0);
    commit(i_ins(6'h08, 0, 6, 16'd40));
    cpu_exec(r_ins(6, 4, 5, 0, 6'h04), c);
    chk("t5_srlv", c.wdata, 32'd0);
    drive(c, 1'b0);
    cpu_exec(r_ins(4, 0, 7, 0, 6'h20), c);
    chk("t5_slt", c.wdata, 32'd1);
    drive(c, 1'b0);
    settle();
    chk("t5_err", 32'(h_err), 32'd0);
    chk("t5_chk", 32'(h_chk), 32'd4);

    // illegal opcode
    do_clear();
    commit({6'b000010, 26'h0000123});
    settle();
    chk("illegal_code", 32'(h_code), 32'd6);

    // saturation of the 4-bit counters
    do_clear();
    for (int j = 0; j < 20; j++) begin
      cpu_exec(i_ins(6'h08, 0, 2, 16'(j + 1)), c);
      c.waddr = 5'd3;
      drive(c, 1'b0);
    end
    settle();
    chk("sat_ecnt", 32'(c_ecnt), 32'd15);
    chk("sat_chk", 32'(c_chk), 32'd15);
    chk("sat_code", 32'(c_code), 32'd4);

    // reset right after a bad commit, then end marker
    do_clear();
    cpu_exec(i_ins(6'h08, 0, 1, 16'd5), c);
    c.wdata = 32'd6;
    drive(c, 1'b0);
    pulse_reset();
    @(negedge clk);
    chk("t6_err", 32'(h_err), 32'd0);
    chk("t6_chk", 32'(h_chk), 32'd0);
    chk("t6_ecnt", 32'(c_ecnt), 32'd0);
    idle(2);
    @(negedge clk);
    chk("t6_err_late", 32'(h_err), 32'd0);
    commit(i_ins(6'h08, 0, 1, 16'd5));
    c = '0; c.valid = 1'b1; c.pc = cpu_pc;
    drive(c, 1'b0);
    commit(i_ins(6'h08, 0, 2, 16'd7));
    settle();
    chk("t6_state", 32'(h_state), 32'd2);
    chk("t6_chk_frozen", 32'(h_chk), 32'd1);

    // randomized run
    do_clear();
    for (int n = 0; n < 700; n++) begin
      k = $urandom_range(0, 99);
      if (k < 2) begin
        do_clear();
      end else if (k < 20) begin
        idle(1);
      end else begin
        k = $urandom_range(0, 13);
        case (k)
          10: ins = i_ins(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
          11: ins = i_ins(6'h0D, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
          12: ins = i_ins(6'h0F, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
          13: begin
            et = $urandom_range(0, 7);
            ins = i_ins(6'h04, et, ($urandom_range(0, 1) == 1) ? et : $urandom_range(0, 7),
                        16'($urandom_range(0, 64)) - 16'd32);
          end
          default: ins = r_ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 31), fl[k]);
        endcase
        if (ins == 32'h0) ins = i_ins(6'h08, 0, 1, 16'd1);
        et = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 0;
        if (et == 6) ins = {6'b000010, 26'($urandom) | 26'h1};
        cpu_exec(ins, c);
        case (et)
          1: c.pc = c.pc ^ 32'h10;
          2: c.next_pc = c.next_pc ^ 32'h4;
          3: c.we = ~c.we;
          4: if (c.we) c.waddr = c.waddr ^ 5'h1; else c.we = 1'b1;
          5: if (c.we) c.wdata = c.wdata ^ (32'h1 << $urandom_range(0, 31)); else c.we = 1'b1;
          default: ;
        endcase
        drive(c, 1'b0);
      end
    end
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
